// File: rtl/tetris_btn.sv
// tetris_btn -- button front end for a falling-block game.
//
// Four raw push-buttons are synchronized, debounced and turned into
// single-cycle command pulses. Left, right and down auto-repeat while held
// (first pulse on press, next after RPT_DELAY cycles, then every RPT_PERIOD
// cycles). Rotate fires once per press. Holding left and right together
// mutes both move outputs while their repeat schedules keep running.
//
// Ports
//   clk                     clock, all logic on rising edge
//   rst_n                   synchronous active-low reset
//   btnL/btnR/btnD/btnS     raw asynchronous buttons, active-high
//   moveL/moveR/moveD       registered single-cycle move pulses
//   rot                     registered single-cycle rotate pulse
//   held[3:0]               debounced levels {S,D,R,L}
module tetris_btn #(
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_DELAY  = 30000000,
  parameter int RPT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       btnS,
  output logic       moveL,
  output logic       moveR,
  output logic       moveD,
  output logic       rot,
  output logic [3:0] held
);

  localparam int DBW     = $clog2(DB_CYCLES + 1);
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RCW     = $clog2(RPT_MAX + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [RCW-1:0] DLY_LAST = RCW'(RPT_DELAY - 1);
  localparam logic [RCW-1:0] PER_LAST = RCW'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [3:0] raw;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] db_lvl;
  logic [2:0] fire;
  logic       conflict;
  logic       rot_prev_q;
  logic       rot_d;
  logic [3:0] out_q;
  logic [3:0] out_d;

  assign raw = {btnS, btnD, btnR, btnL};

  // Two-flop synchronizer, cleared in reset regardless of raw levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debouncer: the counter only runs while the synchronized
  // input disagrees with the accepted level, so it can never wrap.
  for (genvar gi = 0; gi < 4; gi++) begin : gen_db
    logic [DBW-1:0] cnt_q;
    logic [DBW-1:0] cnt_d;
    logic           lvl_q;
    logic           lvl_d;

    always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (sync2_q[gi] == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        cnt_d = '0;
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign db_lvl[gi] = lvl_q;
  end

  // Auto-repeat FSMs for L, R, D. IDLE with the level high means the level
  // has just risen (any low level forces IDLE), so entering DELAY from IDLE
  // is the press edge.
  for (genvar gi = 0; gi < 3; gi++) begin : gen_rpt
    state_t         state_q;
    state_t         state_d;
    logic [RCW-1:0] rcnt_q;
    logic [RCW-1:0] rcnt_d;
    logic           fire_d;

    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      fire_d  = 1'b0;
      if (!db_lvl[gi]) begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_DELAY;
            rcnt_d  = '0;
            fire_d  = 1'b1;
          end
          ST_DELAY: begin
            if (rcnt_q == DLY_LAST) begin
              state_d = ST_REPEAT;
              rcnt_d  = '0;
              fire_d  = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (rcnt_q == PER_LAST) begin
              rcnt_d = '0;
              fire_d = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    assign fire[gi] = fire_d;
  end

  // Rotate: one pulse per debounced rising edge.
  assign rot_d = db_lvl[3] & ~rot_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rot_prev_q <= 1'b0;
    end else begin
      rot_prev_q <= db_lvl[3];
    end
  end

  // Opposing horizontal moves cancel; the FSMs keep their schedule so the
  // survivor resumes on its next slot without a catch-up pulse.
  assign conflict = db_lvl[0] & db_lvl[1];
  assign out_d    = {rot_d, fire[2], fire[1] & ~conflict, fire[0] & ~conflict};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign moveL = out_q[0];
  assign moveR = out_q[1];
  assign moveD = out_q[2];
  assign rot   = out_q[3];
  assign held  = db_lvl;

endmodule
